mac_array_seq: RTL and testbench
================================

# mac_array_seq

Sequencer that sits in front of and behind `mac_array`: it accepts operand vectors on a valid/ready stream, drives the array's `en` and operand inputs for a programmed number of beats, and waits for the accumulators to settle. It then snapshots all `NUM_COL` results and streams them out one column per beat on a valid/ready result port. It replaces testbench-style manual driving of the array in the integrated design.

## Interface
- `WIDTH`, 8, operand width (signed)
- `ACC_WIDTH`, 24, accumulator/result width (signed)
- `NUM_COL`, 4, array columns
- `LEN_WIDTH`, 8, width of the beat-count field
- `SETTLE`, 2, cycles waited after the last accepted beat before capturing `arr_y`

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a run (sampled in IDLE only)
- `len`  in  LEN_WIDTH  operand beats in the run, latched on `start`
- `in_valid`  in  1  operand vector valid
- `in_ready`  out  1  sequencer accepts operands
- `in_a`, `in_b`  in  NUM_COL*WIDTH  packed operand vectors, column 0 in LSBs
- `arr_clr`  out  1  one-cycle accumulator clear to the array
- `arr_en`  out  1  array accumulate enable
- `arr_a`, `arr_b`  out  NUM_COL*WIDTH  registered operands to the array
- `arr_y`  in  NUM_COL*ACC_WIDTH  array accumulator outputs
- `out_valid`  out  1  result beat valid
- `out_ready`  in  1  downstream accepts result
- `out_data`  out  ACC_WIDTH  result of column `out_idx`
- `out_idx`  out  $clog2(NUM_COL)  column index of the current beat
- `out_last`  out  1  high on the column NUM_COL-1 beat
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse after the final result handshake

## Operation
- FSM states: IDLE, CLEAR, LOAD, WAIT, DRAIN.
- IDLE:
  - `start`=1 latches `len` and moves to CLEAR.
  - `start` is ignored in every other state.
- CLEAR:
  - `arr_clr`=1 for exactly one cycle.
  - Next state is LOAD, or WAIT if the latched `len`==0.
- LOAD:
  - `in_ready`=1.
  - Each `in_valid`&&`in_ready` handshake registers `in_a`/`in_b` into `arr_a`/`arr_b` and sets `arr_en`=1 on the next cycle.
  - `arr_en`=0 after any cycle with no handshake.
  - The beat counter increments per handshake. The `len`-th handshake moves to WAIT.
  - `in_ready` drops in the same cycle the state leaves LOAD.
- WAIT:
  - Counts `SETTLE` cycles, then captures all of `arr_y` into internal registers and moves to DRAIN.
  - `arr_a`/`arr_b` hold their last values.
- DRAIN:
  - `out_valid`=1, `out_data`=captured column `out_idx`, starting at index 0.
  - On each handshake `out_idx` increments.
  - A handshake with `out_last`=1 moves to IDLE and pulses `done`.
  - `out_data`/`out_idx` hold stable while `out_valid`&&!`out_ready`.
- Arithmetic: `out_data` is the captured value, bit-exact signed, with no resizing. Overflow is the array's concern.
- `rst` mid-run returns to IDLE. The next run starts with CLEAR, so partial accumulation is discarded.

## Timing
- Reset values are 0 for `in_ready`, `arr_clr`, `arr_en`, `arr_a`, `arr_b`, `out_valid`, `out_data`, `out_idx`, `out_last`, `busy`, `done`.
- `start` -> `arr_clr` high on the next cycle; `in_ready` high the cycle after that.
- Operand handshake at edge N -> `arr_en`/`arr_a`/`arr_b` valid after edge N -> array accumulates at edge N+1.
- Last handshake -> `SETTLE` WAIT cycles -> `out_valid` high. With `SETTLE`=2, the first result is presented 3 cycles after the last handshake.
- With back-to-back `out_ready`=1, a full drain takes NUM_COL cycles. `done` is high the cycle after the last handshake, and `busy` is low in that same cycle.
- Minimum run (`len`=0): CLEAR -> WAIT(`SETTLE`) -> DRAIN. All results are 0.
- `start` is accepted in the cycle `busy` returns low.

## Configuration
- `MAC_SEQ_RELU_EN` defined:
  - Captured results pass through ReLU at capture time (negative -> 0).
- Not defined:
  - Raw signed results are captured and streamed; the ReLU logic is absent.

## Structure
- Shared package `mac_pkg`:
  - state enum `mac_seq_state_t`
  - default `WIDTH`/`ACC_WIDTH`/`NUM_COL` constants
  - the ReLU function used under `MAC_SEQ_RELU_EN`
- One sub-module `mac_seq_drain` holds the capture registers, optional ReLU, column serializer and `out_*` handshake. It returns a `drain_done` to the FSM.
- Top level holds the FSM, beat/settle counters and operand registers.

## Test plan
- Run with `len`=10, constant a={3,-2,7,1}, b={4,5,-1,1}, `in_valid`/`out_ready` always 1 -> results 120, -100, -70, 10 at `out_idx` 0..3; `out_last` on idx 3; single `done` pulse.
- Same vectors with `MAC_SEQ_RELU_EN` -> results 120, 0, 0, 10.
- `in_valid` toggling 1/0 with `len`=4 -> exactly 4 `arr_en` cycles; results 4x the per-beat products (12, -10, -7, 1 per beat -> 48, -40, -28, 4).
- `out_ready` low for 3 cycles on idx 1 -> `out_data`/`out_idx` stable throughout; no beat dropped or duplicated.
- `len`=0 -> `arr_en` never asserted; results 0, 0, 0, 0; `done` pulses.
- `rst` asserted after 5 of 10 beats, then a fresh run with `len`=2 -> `arr_clr` seen again; results 24, -20, -14, 2.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types, default sizes and ReLU helper for the MAC array sequencer
package mac_pkg;

    localparam int MAC_WIDTH     = 8;
    localparam int MAC_ACC_WIDTH = 24;
    localparam int MAC_NUM_COL   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_WAIT,
        S_DRAIN
    } mac_seq_state_t;

    // Callers sign-extend into 64 bits and keep the low ACC_WIDTH bits of the
    // result, so one helper covers any accumulator width up to 64.
    function automatic logic signed [63:0] relu(input logic signed [63:0] v);
        return v[63] ? 64'sd0 : v;
    endfunction

endpackage

// File: rtl/mac_seq_drain.sv
// rtl/mac_seq_drain.sv - result capture, optional ReLU and one-column-per-beat result stream
//
// Optional feature: MAC_SEQ_RELU_EN clamps negative results to 0 at capture time.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   capture         one-cycle strobe: snapshot arr_y and start streaming
//   arr_y           packed accumulator outputs, column 0 in LSBs
//   out_valid/out_ready/out_data/out_idx/out_last  result stream
//   drain_done      handshake of the last column this cycle
module mac_seq_drain
    import mac_pkg::*;
#(
    parameter int ACC_WIDTH = MAC_ACC_WIDTH,
    parameter int NUM_COL   = MAC_NUM_COL,
    parameter int IDX_W     = $clog2(NUM_COL)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         capture,
    input  logic [NUM_COL*ACC_WIDTH-1:0] arr_y,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [ACC_WIDTH-1:0]         out_data,
    output logic [IDX_W-1:0]             out_idx,
    output logic                         out_last,
    output logic                         drain_done
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_COL - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [ACC_WIDTH-1:0] cap    [NUM_COL];
    logic [ACC_WIDTH-1:0] cap_in [NUM_COL];
    logic                 out_hs;

`ifdef MAC_SEQ_RELU_EN
    logic signed [63:0] relu_v;

    always_comb begin
        relu_v = 64'sd0;
        for (int c = 0; c < NUM_COL; c++) begin
            relu_v    = relu(64'(signed'(arr_y[c*ACC_WIDTH +: ACC_WIDTH])));
            cap_in[c] = relu_v[ACC_WIDTH-1:0];
        end
    end
`else
    always_comb begin
        for (int c = 0; c < NUM_COL; c++) begin
            cap_in[c] = arr_y[c*ACC_WIDTH +: ACC_WIDTH];
        end
    end
`endif

    assign out_hs     = out_valid && out_ready;
    assign out_last   = out_valid && (out_idx == IDX_LAST);
    assign drain_done = out_hs && out_last;
    assign out_data   = cap[out_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            for (int c = 0; c < NUM_COL; c++) cap[c] <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_idx   <= '0;
            for (int c = 0; c < NUM_COL; c++) cap[c] <= cap_in[c];
        end else if (out_hs) begin
            if (out_last) begin
                out_valid <= 1'b0;
                out_idx   <= '0;
            end else begin
                out_idx <= out_idx + IDX_ONE;
            end
        end
    end

endmodule

// File: rtl/mac_array_seq.sv
// rtl/mac_array_seq.sv - sequencer feeding mac_array operands and streaming its results
//
// Optional feature: MAC_SEQ_RELU_EN (applied inside mac_seq_drain).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, len                  begin a run of len operand beats (sampled in IDLE)
//   in_valid/in_ready/in_a/in_b operand stream, column 0 in LSBs
//   arr_clr, arr_en, arr_a, arr_b, arr_y   array control, registered operands, results
//   out_valid/out_ready/out_data/out_idx/out_last  result stream, one column per beat
//   busy, done                  run in progress, one-cycle completion pulse
module mac_array_seq
    import mac_pkg::*;
#(
    parameter int WIDTH     = MAC_WIDTH,
    parameter int ACC_WIDTH = MAC_ACC_WIDTH,
    parameter int NUM_COL   = MAC_NUM_COL,
    parameter int LEN_WIDTH = 8,
    parameter int SETTLE    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [LEN_WIDTH-1:0]         len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_COL*WIDTH-1:0]     in_a,
    input  logic [NUM_COL*WIDTH-1:0]     in_b,
    output logic                         arr_clr,
    output logic                         arr_en,
    output logic [NUM_COL*WIDTH-1:0]     arr_a,
    output logic [NUM_COL*WIDTH-1:0]     arr_b,
    input  logic [NUM_COL*ACC_WIDTH-1:0] arr_y,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_WIDTH-1:0]         out_data,
    output logic [$clog2(NUM_COL)-1:0]   out_idx,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);

    localparam int SET_W = $clog2(SETTLE + 1);
    localparam logic [SET_W-1:0]     SETTLE_LAST = SET_W'(SETTLE - 1);
    localparam logic [SET_W-1:0]     SET_ONE     = SET_W'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE     = LEN_WIDTH'(1);

    mac_seq_state_t       state, state_next;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic [SET_W-1:0]     settle_cnt;
    logic                 in_hs;
    logic                 last_beat;
    logic                 settle_end;
    logic                 drain_done;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        arr_clr    = 1'b0;
        busy       = 1'b1;
        in_hs      = 1'b0;
        last_beat  = 1'b0;
        settle_end = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_next = S_CLEAR;
            end
            S_CLEAR: begin
                arr_clr    = 1'b1;
                state_next = (len_q == '0) ? S_WAIT : S_LOAD;
            end
            S_LOAD: begin
                in_ready  = 1'b1;
                in_hs     = in_valid;
                last_beat = in_valid && (beat_cnt + LEN_ONE == len_q);
                if (last_beat) state_next = S_WAIT;
            end
            S_WAIT: begin
                // The capture edge is also the transition into DRAIN, so the
                // first result appears SETTLE+1 cycles after the last beat.
                settle_end = (settle_cnt == SETTLE_LAST);
                if (settle_end) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_done) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            beat_cnt   <= '0;
            settle_cnt <= '0;
            arr_en     <= 1'b0;
            arr_a      <= '0;
            arr_b      <= '0;
            done       <= 1'b0;
        end else begin
            arr_en <= in_hs;
            done   <= drain_done;
            if (state == S_IDLE && start) begin
                len_q    <= len;
                beat_cnt <= '0;
            end else if (in_hs) begin
                beat_cnt <= beat_cnt + LEN_ONE;
            end
            if (in_hs) begin
                arr_a <= in_a;
                arr_b <= in_b;
            end
            if (state == S_WAIT) settle_cnt <= settle_cnt + SET_ONE;
            else                 settle_cnt <= '0;
        end
    end

    mac_seq_drain #(
        .ACC_WIDTH (ACC_WIDTH),
        .NUM_COL   (NUM_COL),
        .IDX_W     ($clog2(NUM_COL))
    ) u_drain (
        .clk        (clk),
        .rst        (rst),
        .capture    (settle_end),
        .arr_y      (arr_y),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .drain_done (drain_done)
    );

endmodule

// File: tb/tb_mac_array_seq.sv
// tb/tb_mac_array_seq.sv - directed self-checking bench for mac_array_seq with a behavioural array
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s: observed %0d expected %0d", tag, obs, exp); end end

module tb_mac_array_seq;

    localparam int W = 8, AW = 24, NC = 4, LW = 8;

    logic            clk = 1'b0;
    logic            rst, start, in_valid, out_ready;
    logic [LW-1:0]   len;
    logic [NC*W-1:0] in_a, in_b, arr_a, arr_b;
    logic [NC*AW-1:0] arr_y;
    logic            in_ready, arr_clr, arr_en, out_valid, out_last, busy, done;
    logic [AW-1:0]   out_data;
    logic [1:0]      out_idx;

    int checks = 0, errors = 0;
    int cyc = 0;

    mac_array_seq #(.WIDTH(W), .ACC_WIDTH(AW), .NUM_COL(NC), .LEN_WIDTH(LW), .SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .arr_clr(arr_clr), .arr_en(arr_en), .arr_a(arr_a), .arr_b(arr_b), .arr_y(arr_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural array: not touched by rst, so only arr_clr can discard old sums.
    logic signed [AW-1:0] acc [NC];
    initial for (int c = 0; c < NC; c++) acc[c] = 24'sd999;
    always @(posedge clk) begin
        for (int c = 0; c < NC; c++) begin
            if (arr_clr)     acc[c] <= '0;
            else if (arr_en) acc[c] <= acc[c] + AW'($signed(arr_a[c*W +: W]) * $signed(arr_b[c*W +: W]));
        end
    end
    always_comb for (int c = 0; c < NC; c++) arr_y[c*AW +: AW] = acc[c];

    // Observation, away from the active edge.
    int en_cnt, clr_cnt, hs_cnt, nbeats, last_hs_cyc, first_ov_cyc, total_done = 0;
    int stall_cycles, stall_err;
    logic        held_valid;
    logic [AW-1:0] held_d;
    logic [1:0]  held_i;
    logic signed [AW-1:0] res_d [8];
    logic [1:0]  res_i [8];
    logic        res_l [8];

    always @(negedge clk) begin
        if (arr_en)  en_cnt++;
        if (arr_clr) clr_cnt++;
        if (done)    total_done++;
        if (in_valid && in_ready) begin hs_cnt++; last_hs_cyc = cyc; end
        if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (out_valid && out_ready) begin
            if (nbeats < 8) begin
                res_d[nbeats] = out_data; res_i[nbeats] = out_idx; res_l[nbeats] = out_last;
            end
            nbeats++;
        end
        if (out_valid && !out_ready) begin
            if (held_valid && (out_data !== held_d || out_idx !== held_i)) stall_err++;
            held_valid = 1'b1; held_d = out_data; held_i = out_idx;
            stall_cycles++;
        end else begin
            held_valid = 1'b0;
        end
    end

    int stall_left;
    bit aborted;

    // Entered and left at posedge+1; when a run completes normally it returns in the
    // cycle done is high, so the next call's start lands in the cycle busy is low.
    task automatic run(input int n, input bit tog, input bit stall, input int abort_at);
        bit got_done = 0;
        en_cnt = 0; clr_cnt = 0; hs_cnt = 0; nbeats = 0;
        last_hs_cyc = -1; first_ov_cyc = -1; stall_cycles = 0; stall_err = 0;
        held_valid = 1'b0; stall_left = 3; aborted = 0;
        start = 1'b1; len = LW'(n); in_valid = 1'b1; out_ready = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin got_done = 1; break; end
            if (abort_at > 0 && hs_cnt >= abort_at) begin
                rst = 1'b1; in_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                aborted = 1;
                return;
            end
            in_valid = tog ? ~in_valid : 1'b1;
            out_ready = !(stall && out_valid && out_idx == 2'd1 && stall_left > 0);
            if (!out_ready) stall_left--;
        end
        `CHK("run_completed", got_done, 1'b1)
        `CHK("busy_low_at_done", busy, 1'b0)
    endtask

    function automatic logic signed [AW-1:0] post(input int v);
`ifdef MAC_SEQ_RELU_EN
        return (v < 0) ? '0 : AW'(v);
`else
        return AW'(v);
`endif
    endfunction

    task automatic check_run(input int n);
        int base [4] = '{12, -10, -7, 1};
        `CHK("beats_out", nbeats, 4)
        `CHK("clr_cycles", clr_cnt, 1)
        `CHK("en_cycles", en_cnt, n)
        if (n > 0) `CHK("result_latency", first_ov_cyc - last_hs_cyc, 3)
        for (int i = 0; i < 4; i++) begin
            `CHK("result_data", res_d[i], post(base[i] * n))
            `CHK("result_idx", res_i[i], 2'(i))
            `CHK("result_last", res_l[i], (i == 3))
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; out_ready = 1'b1;
        // a = {3,-2,7,1}, b = {4,5,-1,1}, column 0 in LSBs
        in_a = {8'd1, 8'd7, 8'hFE, 8'd3};
        in_b = {8'd1, 8'hFF, 8'd5, 8'd4};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        `CHK("rst_in_ready", in_ready, 1'b0)
        `CHK("rst_arr_clr", arr_clr, 1'b0)
        `CHK("rst_arr_en", arr_en, 1'b0)
        `CHK("rst_arr_ab", {arr_a, arr_b}, 64'd0)
        `CHK("rst_out_valid", out_valid, 1'b0)
        `CHK("rst_out_data", out_data, 24'd0)
        `CHK("rst_out_idx_last", {out_idx, out_last}, 3'd0)
        `CHK("rst_busy_done", {busy, done}, 2'd0)
        @(posedge clk); #1;

        run(10, 0, 0, 0);  check_run(10);
        run(4, 1, 0, 0);   check_run(4);
        run(10, 0, 1, 0);  check_run(10);
        `CHK("stall_cycles", stall_cycles, 3)
        `CHK("stall_stable", stall_err, 0)
        run(0, 0, 0, 0);   check_run(0);

        run(10, 0, 0, 5);
        `CHK("abort_taken", aborted, 1'b1)
        `CHK("abort_busy", busy, 1'b0)
        `CHK("abort_out_valid", out_valid, 1'b0)
        run(2, 0, 0, 0);   check_run(2);

        repeat (2) @(posedge clk);
        @(negedge clk);
        `CHK("done_pulses", total_done, 5)

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
